// File: rtl/acc_arb_pkg.sv
// Shared types and helpers for the accumulator group arbiter.
package acc_arb_pkg;

  typedef enum logic [0:0] {
    IDLE   = 1'b0,
    STREAM = 1'b1
  } arb_state_t;

  // Upper bounds on requester count and the tag width that indexes them.
  localparam int unsigned MAX_REQ   = 16;
  localparam int unsigned MAX_TAG_W = 4;

  // Width of a requester tag; a single requester bit is kept for NUM_REQ of 1 or 2.
  function automatic int unsigned tag_width(input int unsigned num_req);
    return (num_req <= 2) ? 32'd1 : 32'($clog2(num_req));
  endfunction

  // First valid requester at or after rr_ptr, wrapping at num_req.
  function automatic logic [MAX_TAG_W-1:0] next_grant(input logic [MAX_REQ-1:0]   valid,
                                                      input logic [MAX_TAG_W-1:0] rr_ptr,
                                                      input int unsigned          num_req);
    logic [MAX_TAG_W-1:0] sel;
    int unsigned          idx;
    sel = rr_ptr;
    // Walk offsets from farthest to nearest so the nearest valid one wins.
    for (int unsigned off = MAX_REQ; off > 0; off--) begin
      if (off <= num_req) begin
        idx = 32'(rr_ptr) + off - 32'd1;
        if (idx >= num_req) begin
          idx = idx - num_req;
        end
        if (valid[idx[MAX_TAG_W-1:0]]) begin
          sel = idx[MAX_TAG_W-1:0];
        end
      end
    end
    return sel;
  endfunction

endpackage

// File: rtl/acc_tag_fifo.sv
// Owner-tag FIFO: one entry per group handed to the accumulator, popped as results return.
module acc_tag_fifo
  import acc_arb_pkg::*;
#(
  parameter int unsigned DEPTH = 16,
  parameter int unsigned TAG_W = 2
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       push,
  input  logic [TAG_W-1:0]           push_tag,
  input  logic                       pop,
  output logic [TAG_W-1:0]           head,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       full,
  output logic                       empty
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  logic [TAG_W-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_q, wr_d;
  logic [PTR_W-1:0] rd_q, rd_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             do_push;
  logic             do_pop;

  // Pointer and occupancy update; pointers wrap naturally because DEPTH is a power of two.
  always_comb begin
    empty   = (cnt_q == '0);
    full    = (cnt_q == CNT_W'(DEPTH));
    do_pop  = pop & ~empty;
    do_push = push & (~full | do_pop);
    wr_d    = wr_q + PTR_W'(do_push);
    rd_d    = rd_q + PTR_W'(do_pop);
    cnt_d   = cnt_q + CNT_W'(do_push) - CNT_W'(do_pop);
    head    = mem_q[rd_q];
    count   = cnt_q;
  end

  // Pointer and count registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      cnt_q <= cnt_d;
    end
  end

  // Tag storage; contents are don't-care while the count says empty.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem_q[wr_q] <= push_tag;
    end
  end

endmodule

// File: rtl/acc_group_arbiter.sv
// Round-robin, whole-group arbiter in front of a shared sequential group accumulator,
// with in-order result routing back to the requester that owned each group.
module acc_group_arbiter
  import acc_arb_pkg::*;
#(
  parameter int unsigned NUM_REQ   = 4,
  parameter int unsigned WIDTH     = 32,
  parameter int unsigned TAG_DEPTH = 16
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [NUM_REQ-1:0]           req_valid,
  input  logic [NUM_REQ*WIDTH-1:0]     req_data,
  input  logic [NUM_REQ-1:0]           req_end_of_group,
  output logic [NUM_REQ-1:0]           req_ready,
  output logic                         acc_valid_in,
  output logic [WIDTH-1:0]             acc_ip,
  output logic                         acc_end_of_group,
  input  logic                         acc_ready,
  input  logic                         acc_valid_out,
  input  logic [WIDTH-1:0]             acc_result,
  output logic                         acc_hold_output,
  output logic [NUM_REQ-1:0]           rsp_valid,
  output logic [WIDTH-1:0]             rsp_result,
  input  logic [NUM_REQ-1:0]           rsp_ready,
  output logic [$clog2(TAG_DEPTH):0]   outstanding,
  output logic                         tag_err
);

  localparam int unsigned TAG_W = tag_width(NUM_REQ);

  typedef logic [TAG_W-1:0] tag_t;

  arb_state_t        state_q, state_d;
  tag_t              grant_q, grant_d;
  tag_t              rr_q, rr_d;
  logic              tag_err_q, tag_err_d;

  logic              sel_valid;
  logic [WIDTH-1:0]  sel_data;
  logic              sel_eog;

  logic              push;
  logic              pop;
  tag_t              head;
  logic              fifo_full;
  logic              fifo_empty;
  logic              head_ready;

  acc_tag_fifo #(
    .DEPTH (TAG_DEPTH),
    .TAG_W (TAG_W)
  ) u_tag_fifo (
    .clk      (clk),
    .rst_n    (rst),
    .push     (push),
    .push_tag (grant_q),
    .pop      (pop),
    .head     (head),
    .count    (outstanding),
    .full     (fifo_full),
    .empty    (fifo_empty)
  );

  // Select the granted requester's beat.
  always_comb begin
    sel_valid = 1'b0;
    sel_data  = '0;
    sel_eog   = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (TAG_W'(i) == grant_q) begin
        sel_valid = req_valid[i];
        sel_data  = req_data[i*WIDTH +: WIDTH];
        sel_eog   = req_end_of_group[i];
      end
    end
  end

  // Next state: grant only when a tag slot is free, release the lock on the last beat.
  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    rr_d    = rr_q;
    push    = 1'b0;
    case (state_q)
      IDLE: begin
        if ((|req_valid) && !fifo_full) begin
          grant_d = TAG_W'(next_grant(MAX_REQ'(req_valid), MAX_TAG_W'(rr_q), NUM_REQ));
          state_d = STREAM;
        end
      end
      STREAM: begin
        if (sel_valid && acc_ready && sel_eog) begin
          push    = 1'b1;
          rr_d    = (grant_q == TAG_W'(NUM_REQ - 1)) ? '0 : grant_q + TAG_W'(1);
          state_d = IDLE;
        end
      end
    endcase
  end

  // Zero-latency pass-through of the locked stream to the accumulator.
  always_comb begin
    req_ready        = '0;
    acc_valid_in     = 1'b0;
    acc_ip           = '0;
    acc_end_of_group = 1'b0;
    if (state_q == STREAM) begin
      acc_valid_in     = sel_valid;
      acc_ip           = sel_data;
      acc_end_of_group = sel_eog;
      for (int i = 0; i < NUM_REQ; i++) begin
        if (TAG_W'(i) == grant_q) begin
          req_ready[i] = acc_ready;
        end
      end
    end
  end

  // Route each result to the head-of-FIFO owner; an untagged result is dropped and flagged.
  always_comb begin
    rsp_valid       = '0;
    rsp_result      = '0;
    acc_hold_output = 1'b0;
    pop             = 1'b0;
    head_ready      = 1'b0;
    tag_err_d       = tag_err_q;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (TAG_W'(i) == head) begin
        head_ready = rsp_ready[i];
      end
    end
    if (acc_valid_out) begin
      if (!fifo_empty) begin
        for (int i = 0; i < NUM_REQ; i++) begin
          rsp_valid[i] = (TAG_W'(i) == head);
        end
        rsp_result      = acc_result;
        acc_hold_output = ~head_ready;
        pop             = head_ready;
      end else begin
        tag_err_d = 1'b1;
      end
    end
  end

  // State, grant, round-robin pointer and sticky error registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= IDLE;
      grant_q   <= '0;
      rr_q      <= '0;
      tag_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      grant_q   <= grant_d;
      rr_q      <= rr_d;
      tag_err_q <= tag_err_d;
    end
  end

  assign tag_err = tag_err_q;

endmodule

// File: doc/acc_group_arbiter.md
Name: acc_group_arbiter

Overview:
- Shares one sequential floating-point group accumulator (fcbtWrapper-style interface: ready, valid_in, ip, end_of_group, valid_out, result, hold_output) between NUM_REQ requester streams.
- Grants the accumulator one whole group at a time, round-robin.
- Records the owner of every submitted group in a tag FIFO, then routes each in-order result back to the owning requester.
- Sits between the per-stream front-ends and the accumulator engine.

Parameters:
NUM_REQ, 4, number of requesters (2..16)
WIDTH, 32, data/result width (IEEE single bits)
TAG_DEPTH, 16, max groups submitted but not yet returned (power of 2; must be <= accumulator output-buffer depth)

Ports:
clk  in  1  clock, all logic on rising edge
rst  in  1  asynchronous, active-low reset
req_valid  in  NUM_REQ  per-requester input beat valid
req_data  in  NUM_REQ x WIDTH  per-requester input beat
req_end_of_group  in  NUM_REQ  beat is last of its group
req_ready  out  NUM_REQ  beat accepted when valid&ready
acc_valid_in  out  1  to accumulator valid_in
acc_ip  out  WIDTH  to accumulator ip
acc_end_of_group  out  1  to accumulator end_of_group
acc_ready  in  1  accumulator ready
acc_valid_out  in  1  accumulator result valid
acc_result  in  WIDTH  accumulator result
acc_hold_output  out  1  stalls accumulator result
rsp_valid  out  NUM_REQ  result valid for requester i
rsp_result  out  WIDTH  result, shared bus
rsp_ready  in  NUM_REQ  requester accepts result
outstanding  out  $clog2(TAG_DEPTH)+1  groups in tag FIFO
tag_err  out  1  sticky: result arrived with tag FIFO empty

Behaviour:
- Reset (rst=0, async): state=IDLE, rr_ptr=0, grant=0, tag FIFO empty, tag_err=0.
  - All outputs 0: req_ready, acc_valid_in, acc_end_of_group, acc_hold_output, rsp_valid, outstanding.
  - Reset mid-group discards the partial group and all tags; the accumulator must be reset in the same window.
- FSM IDLE:
  - If any req_valid and outstanding < TAG_DEPTH, register grant = first requester with req_valid, searching from rr_ptr upward with wrap; go to STREAM.
  - Otherwise stay. When outstanding == TAG_DEPTH, no grant is issued.
- FSM STREAM (combinational pass-through, zero latency):
  - acc_valid_in = req_valid[grant]; acc_ip = req_data[grant]; acc_end_of_group = req_end_of_group[grant].
  - req_ready[grant] = acc_ready; all other req_ready = 0.
  - A beat transfers when req_valid[grant] & acc_ready.
  - Bubbles (req_valid low) keep the lock; the arbiter never preempts mid-group.
  - On a transfer with end_of_group=1: push grant into the tag FIFO, rr_ptr = grant+1 mod NUM_REQ, go to IDLE.
- Timing:
  - First beat of a new group is accepted no earlier than 1 cycle after IDLE samples req_valid.
  - Back-to-back groups therefore cost one idle cycle between them.
  - A 1-beat group takes IDLE, STREAM (1 cycle), IDLE.
- Result path:
  - head = tag FIFO head.
  - If acc_valid_out and FIFO not empty: rsp_valid[head]=1, rsp_result=acc_result, acc_hold_output = ~rsp_ready[head].
  - The result is consumed when acc_valid_out & ~acc_hold_output; a consume pops the FIFO.
  - If acc_valid_out and FIFO empty: tag_err<=1, acc_hold_output=0 (result dropped), no rsp_valid.
  - rsp_valid is 0 whenever acc_valid_out=0.
- Push and pop in the same cycle: outstanding unchanged. Read and write pointers wrap mod TAG_DEPTH.
- Capacity: a grant reserves a slot (outstanding < TAG_DEPTH is checked at grant). Pops only decrease the count, so the end-of-group push never overflows.

Decomposition:
- Package acc_arb_pkg holds:
  - typedef enum {IDLE, STREAM} arb_state_t
  - the tag_t width function $clog2(NUM_REQ), minimum 1
  - the round-robin search function next_grant(valid vector, rr_ptr)
- Sub-module acc_tag_fifo: synchronous FIFO of tag_t with push, pop, head, count, full, empty.
  - Async active-low reset.
  - Simultaneous push and pop are legal.

Test Plan:
- Single requester 0 sends a 3-beat group 1.0, 2.0, 3.0 → accumulator receives 3 beats with end_of_group on the 3rd; outstanding goes 0→1; result 6.0 appears on rsp_valid[0] only; outstanding returns to 0.
- Requesters 0 and 2 both valid at reset release → grant order 0, then 2, then 0 (round-robin), with one IDLE cycle between groups; the accumulator never sees interleaved beats.
- Requester 1 drops req_valid for 5 cycles mid-group while requester 3 is valid → lock held, req_ready[3]=0 throughout, group 1 completes before any grant to 3.
- Hold responder 0 with rsp_ready[0]=0 for 10 cycles while its result is valid → acc_hold_output=1 for those cycles; result delivered intact when ready rises; the next result routes to the correct requester.
- TAG_DEPTH=4, results held off → exactly 4 groups are granted, a 5th requester waits in IDLE; the first pop allows the grant on the next cycle.
- acc_valid_out pulsed with the FIFO empty → tag_err=1 and stays 1; assert rst=0 mid-STREAM → all outputs 0 asynchronously, outstanding=0.
